imm_alu_sequencer: RTL

- Parametrised control sequencer that drives the shared-bus datapath through one complete immediate-ALU instruction (addi, andi, ori).
- Covers fetch (T0-T2) and execute (T3-T5), replacing hand-sequenced control strobes with a real FSM.
- Adds a start/busy/done handshake, a memory-ready stall, and illegal-instruction detection.
- Sits beside the datapath. Consumes the IR contents; drives its register-select and ALU control lines.

---
 rtl/imm_seq_pkg.sv | 40 ++++
 rtl/imm_seq_decode.sv | 53 +++++
 rtl/imm_alu_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/imm_seq_pkg.sv
// Shared definitions for the immediate-ALU control sequencer: state encoding,
// opcodes, ALU function codes and instruction field positions.
package imm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 4;

  localparam logic [OPC_W-1:0] OP_ADDI = 5'b10001;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b10010;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b10011;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  // Field LSB positions; opcode, Ra and Rb are packed from the top of the word.
  function automatic int opc_lsb(input int data_w);
    return data_w - OPC_W;
  endfunction

  function automatic int ra_lsb(input int data_w);
    return data_w - OPC_W - REG_IDX_W;
  endfunction

  function automatic int rb_lsb(input int data_w);
    return data_w - OPC_W - 2 * REG_IDX_W;
  endfunction

endpackage

// File: rtl/imm_seq_decode.sv
// Combinational instruction decode: opcode validity, ALU function,
// one-hot register selects and sign-extended immediate.
module imm_seq_decode
  import imm_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IMM_W  = DATA_W - 13
) (
  input  logic [DATA_W-1:0] ir,
  output logic              op_valid,
  output logic [2:0]        alu_op,
  output logic [NREGS-1:0]  ra_oh,
  output logic [NREGS-1:0]  rb_oh,
  output logic [DATA_W-1:0] c_sext
);

  localparam int OPC_LSB = opc_lsb(DATA_W);
  localparam int RA_LSB  = ra_lsb(DATA_W);
  localparam int RB_LSB  = rb_lsb(DATA_W);

  logic [OPC_W-1:0]     opcode;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;

  assign opcode = ir[OPC_LSB +: OPC_W];
  assign ra     = ir[RA_LSB +: REG_IDX_W];
  assign rb     = ir[RB_LSB +: REG_IDX_W];

  always_comb begin
    op_valid = 1'b1;
    alu_op   = ALU_IDLE;
    case (opcode)
      OP_ADDI: alu_op = ALU_ADD;
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      default: op_valid = 1'b0;
    endcase
  end

  // An index at or above NREGS matches no bit, leaving its vector all-zero.
  always_comb begin
    ra_oh = '0;
    rb_oh = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      ra_oh[i] = (ra == REG_IDX_W'(i));
      rb_oh[i] = (rb == REG_IDX_W'(i));
    end
  end

  assign c_sext = {{(DATA_W - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

endmodule

// File: rtl/imm_alu_sequencer.sv
// Control FSM sequencing fetch (T0-T2) and execute (T3-T5) of one immediate
// ALU instruction over the shared-bus datapath, with start/busy/done handshake.
module imm_alu_sequencer
  import imm_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IMM_W  = DATA_W - 13
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              pc_out,
  output logic              mar_in,
  output logic              inc_pc,
  output logic              md_read,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              zlo_out,
  output logic              z_in,
  output logic              y_in,
  output logic              c_out,
  output logic              pc_in,
  output logic [NREGS-1:0]  reg_out,
  output logic [NREGS-1:0]  reg_in,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] c_sext,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_t state_q, state_d;

  logic             dec_op_valid;
  logic [2:0]       dec_alu_op;
  logic [NREGS-1:0] dec_ra_oh;
  logic [NREGS-1:0] dec_rb_oh;
  logic             legal;
  logic             in_t3;

  imm_seq_decode #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IMM_W  (IMM_W)
  ) u_decode (
    .ir       (ir),
    .op_valid (dec_op_valid),
    .alu_op   (dec_alu_op),
    .ra_oh    (dec_ra_oh),
    .rb_oh    (dec_rb_oh),
    .c_sext   (c_sext)
  );

  assign legal = dec_op_valid & (|dec_ra_oh) & (|dec_rb_oh);
  assign in_t3 = (state_q == S_T3);

  logic             pc_out_d, mar_in_d, inc_pc_d, md_read_d, mdr_in_d;
  logic             mdr_out_d, ir_in_d, zlo_out_d, z_in_d, c_out_d, pc_in_d;
  logic             busy_d, done_d;
  logic [NREGS-1:0] reg_in_d;
  logic [2:0]       alu_op_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = legal ? S_T4 : S_IDLE;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out_d  = 1'b0;
    mar_in_d  = 1'b0;
    inc_pc_d  = 1'b0;
    md_read_d = 1'b0;
    mdr_in_d  = 1'b0;
    mdr_out_d = 1'b0;
    ir_in_d   = 1'b0;
    zlo_out_d = 1'b0;
    z_in_d    = 1'b0;
    c_out_d   = 1'b0;
    pc_in_d   = 1'b0;
    done_d    = 1'b0;
    reg_in_d  = '0;
    alu_op_d  = ALU_IDLE;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_T0: begin
        pc_out_d = 1'b1;
        mar_in_d = 1'b1;
        inc_pc_d = 1'b1;
        z_in_d   = 1'b1;
      end
      S_T1: begin
        zlo_out_d = 1'b1;
        md_read_d = 1'b1;
        mdr_in_d  = 1'b1;
        // Load the incremented PC once, not on every memory stall cycle.
        pc_in_d   = (state_q != S_T1);
      end
      S_T2: begin
        mdr_out_d = 1'b1;
        ir_in_d   = 1'b1;
      end
      S_T4: begin
        c_out_d  = 1'b1;
        z_in_d   = 1'b1;
        alu_op_d = dec_alu_op;
      end
      S_T5: begin
        zlo_out_d = 1'b1;
        reg_in_d  = dec_ra_oh;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      pc_out  <= 1'b0;
      mar_in  <= 1'b0;
      inc_pc  <= 1'b0;
      md_read <= 1'b0;
      mdr_in  <= 1'b0;
      mdr_out <= 1'b0;
      ir_in   <= 1'b0;
      zlo_out <= 1'b0;
      z_in    <= 1'b0;
      c_out   <= 1'b0;
      pc_in   <= 1'b0;
      reg_in  <= '0;
      alu_op  <= ALU_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_out  <= pc_out_d;
      mar_in  <= mar_in_d;
      inc_pc  <= inc_pc_d;
      md_read <= md_read_d;
      mdr_in  <= mdr_in_d;
      mdr_out <= mdr_out_d;
      ir_in   <= ir_in_d;
      zlo_out <= zlo_out_d;
      z_in    <= z_in_d;
      c_out   <= c_out_d;
      pc_in   <= pc_in_d;
      reg_in  <= reg_in_d;
      alu_op  <= alu_op_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // T3 strobes gate the registered T3 state with decode of the IR as loaded
  // at the end of T2; decoding earlier would see the previous instruction.
  assign reg_out = (in_t3 && legal) ? dec_rb_oh : '0;
  assign y_in    = in_t3 & legal;
  assign illegal = in_t3 & ~legal;

endmodule
